score_display_ctrl: RTL and testbench

//  Game-side controller that owns the score and hi-score registers. It sequences a shared

---
 rtl/score_pkg.sv | 27 ++
 rtl/score_display_ctrl_bin2bcd.sv | 50 +++++
 rtl/score_display_ctrl.sv | 163 ++++++++++++++++
 tb/tb_score_display_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score display controller and its BCD converter.
package score_pkg;

    localparam int SCORE_W           = 8;
    localparam int BCD_W             = 8;
    localparam int DEFAULT_MAX_SCORE = 99;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_SCORE = 2'd1,
        SEQ_HI    = 2'd2
    } seq_t;

    function automatic logic [SCORE_W-1:0] satInc(
        input logic [SCORE_W-1:0] value,
        input logic [SCORE_W-1:0] ceiling
    );
        return (value >= ceiling) ? ceiling : value + 8'd1;
    endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd.sv
// Repeated-subtraction binary-to-BCD converter for values 0..99.
// A go pulse loads the value, each following cycle removes one ten, and done pulses with the digits.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [SCORE_W-1:0] bin,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    logic               r_active;
    logic [SCORE_W-1:0] r_rem;
    logic [3:0]         r_tens;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_rem    <= '0;
            r_tens   <= '0;
            r_done   <= 1'b0;
            r_bcd    <= '0;
        end else begin
            r_done <= 1'b0;
            if (go) begin
                r_active <= 1'b1;
                r_rem    <= bin;
                r_tens   <= '0;
            end else if (r_active) begin
                if (r_rem >= 8'd10) begin
                    r_rem  <= r_rem - 8'd10;
                    r_tens <= r_tens + 4'd1;
                end else begin
                    // Remainder below ten is the ones digit; finish this cycle.
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                    r_bcd    <= {r_tens, r_rem[3:0]};
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/score_display_ctrl.sv
// Game-side score/hi-score owner: game FSM, two-pass BCD conversion sequencer and hi-score blink gate.
// Digit outputs change only once both values of a pass have been converted, so they always agree.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int MAX_SCORE  = DEFAULT_MAX_SCORE,
    parameter int BLINK_BITS = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               point,
    input  logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hiscore,
    output logic [BCD_W-1:0]   dig_score,
    output logic [BCD_W-1:0]   dig_hi,
    output logic               busy,
    output logic               new_hi,
    output logic               blank_hi
);

    localparam logic [SCORE_W-1:0]    MAX_S   = SCORE_W'(MAX_SCORE);
    localparam logic [BLINK_BITS-1:0] CNT_ONE = BLINK_BITS'(1);

    state_t                r_state;
    logic [SCORE_W-1:0]    r_score;
    logic [SCORE_W-1:0]    r_hiscore;
    logic                  r_newHi;
    logic                  r_dirty;
    seq_t                  r_seq;
    logic [SCORE_W-1:0]    r_hiLatch;
    logic [BCD_W-1:0]      r_bcdScore;
    logic [BCD_W-1:0]      r_digScore;
    logic [BCD_W-1:0]      r_digHi;
    logic                  r_busy;
    logic [BLINK_BITS-1:0] r_cnt;

    logic               w_startOk;
    logic               w_pointOk;
    logic               w_overOk;
    logic               w_event;
    logic [SCORE_W-1:0] w_nextScore;
    logic               w_record;
    logic               w_launch;
    logic               w_convGo;
    logic [SCORE_W-1:0] w_convBin;
    logic               w_convDone;
    logic [BCD_W-1:0]   w_convBcd;

    assign w_startOk = start && (r_state != S_PLAY);
    assign w_pointOk = point && (r_state == S_PLAY);
    assign w_overOk  = game_over && (r_state == S_PLAY);
    assign w_event   = w_startOk || w_pointOk || w_overOk;

    // A point arriving with game_over is counted before the record compare.
    assign w_nextScore = w_pointOk ? satInc(r_score, MAX_S) : r_score;
    assign w_record    = w_overOk && (w_nextScore > r_hiscore);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_score   <= '0;
            r_hiscore <= '0;
            r_newHi   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_state <= S_PLAY;
                        r_score <= '0;
                        r_newHi <= 1'b0;
                    end
                end
                S_PLAY: begin
                    r_score <= w_nextScore;
                    if (game_over) begin
                        r_state <= S_OVER;
                        if (w_record) begin
                            r_hiscore <= w_nextScore;
                            r_newHi   <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Score is fed straight into the converter at launch; hiscore is held until the second pass.
    assign w_launch  = (r_seq == SEQ_IDLE) && r_dirty;
    assign w_convGo  = w_launch || ((r_seq == SEQ_SCORE) && w_convDone);
    assign w_convBin = w_launch ? r_score : r_hiLatch;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (w_convGo),
        .bin   (w_convBin),
        .done  (w_convDone),
        .bcd   (w_convBcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dirty    <= 1'b0;
            r_seq      <= SEQ_IDLE;
            r_hiLatch  <= '0;
            r_bcdScore <= '0;
            r_digScore <= '0;
            r_digHi    <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_seq)
                SEQ_IDLE: begin
                    if (r_dirty) begin
                        r_seq     <= SEQ_SCORE;
                        r_busy    <= 1'b1;
                        r_hiLatch <= r_hiscore;
                    end
                end
                SEQ_SCORE: begin
                    if (w_convDone) begin
                        r_bcdScore <= w_convBcd;
                        r_seq      <= SEQ_HI;
                    end
                end
                SEQ_HI: begin
                    if (w_convDone) begin
                        r_digScore <= r_bcdScore;
                        r_digHi    <= w_convBcd;
                        r_busy     <= 1'b0;
                        r_seq      <= SEQ_IDLE;
                    end
                end
                default: r_seq <= SEQ_IDLE;
            endcase
            // A new event in the launch cycle must survive so it triggers another pass.
            if (w_event) begin
                r_dirty <= 1'b1;
            end else if (w_launch) begin
                r_dirty <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign score     = r_score;
    assign hiscore   = r_hiscore;
    assign dig_score = r_digScore;
    assign dig_hi    = r_digHi;
    assign busy      = r_busy;
    assign new_hi    = r_newHi;
    assign blank_hi  = r_newHi && r_cnt[BLINK_BITS-1] && (r_state == S_OVER);

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: game-rule model checked every cycle plus directed scenarios.
// Randomized pulse traffic at the end exercises events arriving at arbitrary points of a conversion.
module tb_score_display_ctrl;

    localparam int BB = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       point;
    logic       game_over;
    logic [7:0] score;
    logic [7:0] hiscore;
    logic [7:0] dig_score;
    logic [7:0] dig_hi;
    logic       busy;
    logic       new_hi;
    logic       blank_hi;

    int nChecks = 0;
    int nErrors = 0;

    int mScore;
    int mHi;
    bit mNew;
    bit mPlay;
    bit mOver;
    int mCnt;

    int histScore[$];
    int histHi[$];
    bit prevBusy;
    int busyRun;
    int busyRises = 0;

    score_display_ctrl #(
        .MAX_SCORE  (99),
        .BLINK_BITS (BB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .point     (point),
        .game_over (game_over),
        .score     (score),
        .hiscore   (hiscore),
        .dig_score (dig_score),
        .dig_hi    (dig_hi),
        .busy      (busy),
        .new_hi    (new_hi),
        .blank_hi  (blank_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int toBcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // Game rules: what score, record and blink gate must be after each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mScore = 0;
            mHi    = 0;
            mNew   = 0;
            mPlay  = 0;
            mOver  = 0;
            mCnt   = 0;
        end else begin
            mCnt = (mCnt + 1) % (1 << BB);
            if (mPlay) begin
                if (point) mScore = (mScore < 99) ? mScore + 1 : 99;
                if (game_over) begin
                    if (mScore > mHi) begin
                        mHi  = mScore;
                        mNew = 1;
                    end
                    mPlay = 0;
                    mOver = 1;
                end
            end else if (start) begin
                mScore = 0;
                mNew   = 0;
                mPlay  = 1;
                mOver  = 0;
            end
        end
    end

    // Every-cycle comparison against the model, plus sanity on every finished conversion pass.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevBusy = 0;
            busyRun  = 0;
            histScore.delete();
            histHi.delete();
        end else begin
            bit found;
            histScore.push_back(mScore);
            histHi.push_back(mHi);
            if (histScore.size() > 30) void'(histScore.pop_front());
            if (histHi.size() > 30) void'(histHi.pop_front());
            checkOutput("score", score, mScore);
            checkOutput("hiscore", hiscore, mHi);
            checkOutput("new_hi", new_hi, mNew);
            checkOutput("blank_hi", blank_hi, int'(mNew && mOver && ((mCnt >> (BB - 1)) & 1)));
            checkOutput("dig_valid",
                        int'(dig_score[7:4] <= 9 && dig_score[3:0] <= 9 &&
                             dig_hi[7:4] <= 9 && dig_hi[3:0] <= 9), 1);
            if (busy) busyRun++;
            if (!prevBusy && busy) busyRises++;
            if (prevBusy && !busy) begin
                checkOutput("busy_run_len_ok", int'(busyRun <= 23), 1);
                found = 0;
                foreach (histScore[i]) if (toBcd(histScore[i]) == dig_score) found = 1;
                checkOutput("dig_score_recent_value", found ? dig_score : -1, dig_score);
                found = 0;
                foreach (histHi[i]) if (toBcd(histHi[i]) == dig_hi) found = 1;
                checkOutput("dig_hi_recent_value", found ? dig_hi : -1, dig_hi);
                busyRun = 0;
            end
            prevBusy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit p, input bit g);
        start     = s;
        point     = p;
        game_over = g;
        @(posedge clk);
        #1;
        start     = 0;
        point     = 0;
        game_over = 0;
    endtask

    task automatic waitSettle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        @(posedge clk);
        #1;
        checkOutput("settle_within_bound", int'(quiet >= 3), 1);
    endtask

    initial begin
        int highs;
        int base;
        int n;
        bit s;
        bit p;
        bit g;
        bit stayedClear;
        rst_n     = 0;
        start     = 0;
        point     = 0;
        game_over = 0;
        tick(3);

        // Reset values.
        checkOutput("rst_score", score, 0);
        checkOutput("rst_hiscore", hiscore, 0);
        checkOutput("rst_dig_score", dig_score, 0);
        checkOutput("rst_dig_hi", dig_hi, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_new_hi", new_hi, 0);
        checkOutput("rst_blank_hi", blank_hi, 0);
        rst_n = 1;
        tick(2);

        // First game: conversion of zero finishes quickly.
        applyStimulus(1, 0, 0);
        n = 0;
        while (n < 6 && !busy) begin tick(1); n++; end
        checkOutput("start_busy_seen", busy, 1);
        n = 0;
        while (n < 6 && busy) begin tick(1); n++; end
        checkOutput("start_conv_fast", int'(!busy), 1);
        checkOutput("start_dig_score", dig_score, 8'h00);

        // Twelve spaced points.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 0);
            tick(29);
        end
        waitSettle();
        checkOutput("twelve_score", score, 12);
        checkOutput("twelve_dig_score", dig_score, 8'h12);

        // Reach 15 and set a record; watch the blink gate.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            highs += int'(blank_hi);
            tick(1);
        end
        checkOutput("record_blink_highs", highs, 16);
        waitSettle();
        checkOutput("record_hiscore", hiscore, 15);
        checkOutput("record_dig_hi", dig_hi, 8'h15);
        checkOutput("record_new_hi", new_hi, 1);

        // Lower score does not replace the record.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        waitSettle();
        checkOutput("low_hiscore", hiscore, 15);
        checkOutput("low_new_hi", new_hi, 0);
        checkOutput("low_dig_score", dig_score, 8'h07);
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            highs += int'(blank_hi);
            tick(1);
        end
        checkOutput("low_blink_highs", highs, 0);

        // Saturation at 99.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 105; i++) applyStimulus(0, 1, 0);
        waitSettle();
        checkOutput("sat_score", score, 99);
        checkOutput("sat_dig_score", dig_score, 8'h99);
        applyStimulus(0, 1, 0);
        waitSettle();
        checkOutput("sat_extra_point", score, 99);
        applyStimulus(0, 0, 1);
        waitSettle();
        checkOutput("sat_dig_hi", dig_hi, 8'h99);

        // Three points during a conversion force a second pass.
        base = busyRises;
        applyStimulus(1, 0, 0);
        tick(1);
        checkOutput("busy_after_start", busy, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
        waitSettle();
        checkOutput("busy_points_score", score, 3);
        checkOutput("busy_points_passes", busyRises - base, 2);
        checkOutput("busy_points_dig", dig_score, 8'h03);

        // Point and game_over together: the incremented score is compared.
        rst_n = 0;
        tick(2);
        rst_n = 1;
        tick(1);
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0);
        waitSettle();
        applyStimulus(0, 1, 1);
        waitSettle();
        checkOutput("both_hiscore", hiscore, 15);
        checkOutput("both_new_hi", new_hi, 1);
        checkOutput("both_dig_hi", dig_hi, 8'h15);

        // Reset in the middle of a conversion.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 25; i++) applyStimulus(0, 1, 0);
        n = 0;
        while (n < 20 && !busy) begin tick(1); n++; end
        checkOutput("midrst_busy_before", busy, 1);
        rst_n = 0;
        #2;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_dig_score", dig_score, 0);
        checkOutput("midrst_dig_hi", dig_hi, 0);
        tick(2);
        rst_n = 1;
        stayedClear = 1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (busy || dig_score != 0 || dig_hi != 0) stayedClear = 0;
        end
        checkOutput("midrst_no_stale_update", stayedClear, 1);

        // Random traffic with periodic settled-digit checks.
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                s = ($urandom_range(0, 99) < 3);
                p = ($urandom_range(0, 99) < 35);
                g = ($urandom_range(0, 99) < 2);
                applyStimulus(s, p, g);
            end
            waitSettle();
            checkOutput("rand_dig_score", dig_score, toBcd(mScore));
            checkOutput("rand_dig_hi", dig_hi, toBcd(mHi));
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
